// File: rtl/sample_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sample_buffer_arbiter
// Purpose  : Shares the single-port sample RAM between the writer and the
//            reader. Arbitration is round-robin by default; defining
//            SBA_WRITE_PRIORITY_EN gives the writer fixed priority instead.
// Revision : 1.0
// ============================================================================
module sample_buffer_arbiter #(
    parameter int DEPTH   = 62500,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RWAIT = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_depth     = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] c_one       = ADDR_W'(1);
    localparam logic [1:0]        c_lat_last  = 2'(MEM_LAT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W-1:0]   r_count;
    logic                r_wr_pend;
    logic                r_rd_pend;
    logic [DATA_W-1:0]   r_wbuf;
    logic [1:0]          r_lat_cnt;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                r_overflow;
    logic                r_underrun;
`ifndef SBA_WRITE_PRIORITY_EN
    logic                r_last_grant;
`endif

    logic                w_full;
    logic                w_empty;
    logic                w_wr_take;
    logic                w_wr_dup;
    logic                w_rd_take;
    logic                w_rd_busy;
    logic                w_wr_pending;
    logic                w_rd_pending;
    logic                w_lat_done;
    logic                w_do_write;
    logic                w_do_read;

    assign w_full     = (r_count == c_depth);
    assign w_empty    = (r_count == '0);
    assign w_rd_busy  = (r_state == S_READ) || (r_state == S_RWAIT);
    assign w_wr_dup   = wr_req && enable && (r_wr_pend || (r_state == S_WRITE));
    assign w_wr_take  = wr_req && enable && !r_wr_pend && (r_state != S_WRITE);
    assign w_rd_take  = rd_req && enable && !r_rd_pend && !w_rd_busy;
    // Same-cycle strobes count as pending so an idle arbiter grants immediately.
    assign w_wr_pending = enable && (r_wr_pend || w_wr_take);
    assign w_rd_pending = enable && (r_rd_pend || w_rd_take);
    assign w_lat_done = (r_lat_cnt == c_lat_last);
    assign w_do_write = (r_state == S_WRITE) && !w_full;
    assign w_do_read  = (r_state == S_READ) && !w_empty;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
`ifdef SBA_WRITE_PRIORITY_EN
                if (w_wr_pending)
                    w_next_state = S_WRITE;
                else if (w_rd_pending)
                    w_next_state = S_READ;
`else
                if (w_wr_pending && w_rd_pending)
                    w_next_state = r_last_grant ? S_WRITE : S_READ;
                else if (w_wr_pending)
                    w_next_state = S_WRITE;
                else if (w_rd_pending)
                    w_next_state = S_READ;
`endif
            end
            S_WRITE: w_next_state = S_IDLE;
            S_READ:  w_next_state = S_RWAIT;
            S_RWAIT: if (w_lat_done) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mem_en    = w_do_write || w_do_read;
        mem_we    = w_do_write;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_do_write) begin
            mem_addr  = r_wr_ptr;
            mem_wdata = r_wbuf;
        end else if (w_do_read) begin
            mem_addr  = r_rd_ptr;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_wr_pend    <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_wbuf       <= '0;
            r_lat_cnt    <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_overflow   <= 1'b0;
            r_underrun   <= 1'b0;
`ifndef SBA_WRITE_PRIORITY_EN
            r_last_grant <= 1'b0;
`endif
        end else begin
            r_state    <= w_next_state;
            r_rd_valid <= 1'b0;

            if (!enable) begin
                r_wr_pend <= 1'b0;
                r_rd_pend <= 1'b0;
            end else begin
                if (w_wr_take) begin
                    r_wr_pend <= 1'b1;
                    r_wbuf    <= wr_data;
                end
                if (w_rd_take)
                    r_rd_pend <= 1'b1;
            end
            if (w_wr_dup)
                r_overflow <= 1'b1;

            case (r_state)
                S_IDLE: begin
`ifndef SBA_WRITE_PRIORITY_EN
                    if (w_next_state == S_WRITE)
                        r_last_grant <= 1'b0;
                    else if (w_next_state == S_READ)
                        r_last_grant <= 1'b1;
`endif
                end
                S_WRITE: begin
                    r_wr_pend <= 1'b0;
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_wr_ptr <= (r_wr_ptr == c_last_addr) ? '0 : r_wr_ptr + c_one;
                        r_count  <= r_count + c_one;
                    end
                end
                S_READ: begin
                    r_rd_pend <= 1'b0;
                    r_lat_cnt <= '0;
                    // An empty read still walks through RWAIT but returns zero at once.
                    if (w_empty) begin
                        r_underrun <= 1'b1;
                        r_rd_data  <= '0;
                        r_rd_valid <= 1'b1;
                    end
                end
                S_RWAIT: begin
                    r_lat_cnt <= r_lat_cnt + 2'd1;
                    if (w_lat_done && !w_empty) begin
                        r_rd_data  <= mem_rdata;
                        r_rd_valid <= 1'b1;
                        r_rd_ptr   <= (r_rd_ptr == c_last_addr) ? '0 : r_rd_ptr + c_one;
                        r_count    <= r_count - c_one;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_ack   = w_do_write;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_sample_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_buffer_arbiter
// Purpose  : Directed bench for sample_buffer_arbiter at DEPTH=8 with a
//            one-cycle RAM model and a FIFO scoreboard of written samples.
// Revision : 1.0
// ============================================================================
module tb_sample_buffer_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        wr_req;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        rd_req;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [15:0] count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        underrun;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] q[$];
    int          wr_ptr_m = 0;
    int          rd_ptr_m = 0;
    logic [15:0] ram [0:7];

    always #5 clock = ~clock;

    sample_buffer_arbiter #(
        .DEPTH   (8),
        .ADDR_W  (16),
        .DATA_W  (16),
        .MEM_LAT (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underrun  (underrun)
    );

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[2:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[2:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives strobes for one cycle (caller sits just after a rising edge), then
    // watches ncyc cycles; writes feed the scoreboard, rd_valid drains it.
    task automatic run_op(input logic do_wr, input logic do_rd, input logic [15:0] data,
                          input int ncyc, output int f_wr, output int f_rd, output int f_rv);
        logic [15:0] exp;
        f_wr = 0; f_rd = 0; f_rv = 0;
        wr_req = do_wr; rd_req = do_rd; wr_data = data;
        @(posedge clock); #1;
        wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clock);
            if (wr_ack && f_wr == 0) begin
                f_wr = i;
                check("wr_addr", mem_addr, wr_ptr_m);
                check("wr_wdata", mem_wdata, data);
                q.push_back(data);
                wr_ptr_m = (wr_ptr_m == 7) ? 0 : wr_ptr_m + 1;
            end
            if (mem_en && !mem_we && f_rd == 0) begin
                f_rd = i;
                check("rd_addr", mem_addr, rd_ptr_m);
                rd_ptr_m = (rd_ptr_m == 7) ? 0 : rd_ptr_m + 1;
            end
            if (rd_valid && f_rv == 0) begin
                f_rv = i;
                exp = (q.size() > 0) ? q.pop_front() : 16'h0000;
                check("rd_data", rd_data, exp);
            end
        end
        @(posedge clock); #1;
    endtask

    initial begin
        int fw, fr, fv;
        logic [15:0] d;
        logic rv_seen;

        reset = 1'b0; enable = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("rst_outputs", {wr_ack, rd_valid, mem_en, mem_we, full, overflow, underrun}, 7'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_count", count, 16'd0);
        check("rst_rd_data", rd_data, 16'd0);
        check("rst_mem_bus", {mem_addr, mem_wdata}, 32'd0);
        @(posedge clock); #1;

        // Fill to full, then one write too many.
        for (int i = 1; i <= 8; i++) begin
            run_op(1'b1, 1'b0, 16'(i), 3, fw, fr, fv);
            check("wr_ack_latency", fw, 1);
        end
        check("fill_count", count, 16'd8);
        check("fill_full", full, 1'b1);
        run_op(1'b1, 1'b0, 16'h0009, 3, fw, fr, fv);
        check("full_no_ack", fw, 0);
        check("full_overflow", overflow, 1'b1);
        check("full_count", count, 16'd8);

        // Drain in order, then read while empty.
        for (int i = 1; i <= 8; i++) begin
            run_op(1'b0, 1'b1, 16'h0000, 5, fw, fr, fv);
            check("rd_mem_en_latency", fr, 1);
            check("rd_valid_latency", fv, 3);
        end
        check("drain_empty", empty, 1'b1);
        check("drain_underrun_clear", underrun, 1'b0);
        run_op(1'b0, 1'b1, 16'h0000, 5, fw, fr, fv);
        check("empty_rd_no_mem", fr, 0);
        check("empty_rd_valid", fv, 2);
        check("empty_underrun", underrun, 1'b1);

        // Pointer wrap with write/read pairs.
        for (int i = 0; i < 20; i++) begin
            d = 16'($urandom);
            run_op(1'b1, 1'b0, d, 3, fw, fr, fv);
            check("wrap_wr_ack", fw, 1);
            run_op(1'b0, 1'b1, 16'h0000, 5, fw, fr, fv);
            check("wrap_rd_valid", fv, 3);
        end
        check("wrap_count", count, 16'd0);

        // Simultaneous requests after a write (writer served last).
        run_op(1'b1, 1'b0, 16'hA5A5, 3, fw, fr, fv);
        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom);
            run_op(1'b1, 1'b1, d, 8, fw, fr, fv);
`ifdef SBA_WRITE_PRIORITY_EN
            check("both_wr_cycle", fw, 1);
            check("both_rd_cycle", fr, 3);
            check("both_rv_cycle", fv, 5);
`else
            check("both_rd_cycle", fr, 1);
            check("both_wr_cycle", fw, 4);
            check("both_rv_cycle", fv, 3);
`endif
        end
        check("both_count", count, 16'd1);

        // Reset while a read sits in RWAIT.
        run_op(1'b1, 1'b0, 16'h1234, 3, fw, fr, fv);
        rd_req = 1'b1;
        @(posedge clock); #1 rd_req = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        rv_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (rd_valid) rv_seen = 1'b1;
        end
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        check("abort_no_valid", rv_seen, 1'b0);
        check("abort_count", count, 16'd0);
        check("abort_empty", empty, 1'b1);
        check("abort_sticky_clear", {overflow, underrun}, 2'b00);
        @(posedge clock); #1;
        q.delete();
        wr_ptr_m = 0;
        rd_ptr_m = 0;
        run_op(1'b1, 1'b0, 16'hBEEF, 3, fw, fr, fv);
        check("post_rst_wr_ack", fw, 1);
        run_op(1'b0, 1'b1, 16'h0000, 5, fw, fr, fv);
        check("post_rst_rd_valid", fv, 3);

        // Requests are ignored while disabled.
        enable = 1'b0;
        run_op(1'b1, 1'b0, 16'h5555, 3, fw, fr, fv);
        check("disabled_no_ack", fw, 0);
        check("disabled_count", count, 16'd0);
        check("disabled_overflow", overflow, 1'b0);
        enable = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
